// File: rtl/binarysearch_datapath.sv
// Binary-search datapath: holds target A and bounds L/R/M, addresses a sorted synchronous RAM
// and flags found/not-found. Define BSEARCH_STATS_EN to add the `probes` compare counter.
module binarysearch_datapath #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_A,
  input  logic                  set_L,
  input  logic                  set_R,
  input  logic                  set_M,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] found_addr,
  output logic                  F,
  output logic                  NF
`ifdef BSEARCH_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   probes
`endif
);

  localparam logic [ADDR_WIDTH-1:0] MaxAddr = '1;

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] l_q, l_d;
  logic [ADDR_WIDTH-1:0] r_q, r_d;
  logic [ADDR_WIDTH-1:0] m_q, m_d;
  logic                  found_q, found_d;
  logic                  nf_q, nf_d;

  logic                  init, probe, cmp;
  logic                  eq, lt, miss;
  logic [ADDR_WIDTH:0]   sum;
  logic [ADDR_WIDTH-1:0] mid;

  assign init  = load_A;
  assign probe = set_M & ~set_L & ~set_R & ~load_A;
  assign cmp   = set_M & set_L & set_R & ~load_A;

  // Extra carry bit keeps L+R exact before halving.
  assign sum = {1'b0, l_q} + {1'b0, r_q};
  assign mid = sum[ADDR_WIDTH:1];

  assign eq   = (mem_data == a_q);
  assign lt   = (mem_data < a_q);
  assign miss = ~eq & ((lt & (m_q == r_q)) | (~lt & (m_q == l_q)));

  assign mem_addr   = mid;
  assign found_addr = m_q;
  assign F          = reset_n & (found_q | (cmp & eq));
  assign NF         = reset_n & (nf_q | (cmp & miss));

  always_comb begin
    a_d     = a_q;
    l_d     = l_q;
    r_d     = r_q;
    m_d     = m_q;
    found_d = found_q;
    nf_d    = nf_q;
    if (init) begin
      a_d     = A_in;
      l_d     = '0;
      r_d     = MaxAddr;
      m_d     = '0;
      found_d = 1'b0;
      nf_d    = 1'b0;
    end else if (probe) begin
      m_d = mid;
    end else if (cmp) begin
      if (eq) begin
        found_d = 1'b1;
      end else if (lt) begin
        // Guards stop at the edge so M+1 / M-1 never wrap.
        if (m_q == r_q) nf_d = 1'b1;
        else            l_d  = m_q + ADDR_WIDTH'(1);
      end else begin
        if (m_q == l_q) nf_d = 1'b1;
        else            r_d  = m_q - ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      found_q <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      l_q     <= l_d;
      r_q     <= r_d;
      m_q     <= m_d;
      found_q <= found_d;
      nf_q    <= nf_d;
    end
  end

`ifdef BSEARCH_STATS_EN
  logic [ADDR_WIDTH:0] probes_q, probes_d;

  always_comb begin
    probes_d = probes_q;
    if (init) begin
      probes_d = '0;
    end else if (cmp && !(found_q || nf_q) && (probes_q != '1)) begin
      probes_d = probes_q + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) probes_q <= '0;
    else          probes_q <= probes_d;
  end

  assign probes = probes_q;
`endif

endmodule

// File: tb/tb_binarysearch_datapath.sv
// Directed bench for binarysearch_datapath: strobes are driven directly and a RAM model
// holding RAM[i]=2*i answers with one cycle of read latency.
module tb_binarysearch_datapath;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_A, set_L, set_R, set_M;
  logic [7:0] A_in;
  logic [7:0] mem_data;
  logic [4:0] mem_addr;
  logic [4:0] found_addr;
  logic       F, NF;
`ifdef BSEARCH_STATS_EN
  logic [5:0] probes;
`endif

  int errors = 0;
  int checks = 0;

  binarysearch_datapath #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_A    (load_A),
    .set_L     (set_L),
    .set_R     (set_R),
    .set_M     (set_M),
    .A_in      (A_in),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .found_addr(found_addr),
    .F         (F),
    .NF        (NF)
`ifdef BSEARCH_STATS_EN
    ,
    .probes    (probes)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous RAM model, RAM[i] = 2*i.
  always @(posedge clock) mem_data <= {2'b00, mem_addr, 1'b0};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_strobes();
    load_A = 1'b0; set_L = 1'b0; set_R = 1'b0; set_M = 1'b0;
  endtask

  task automatic do_init(input logic [7:0] a);
    load_A = 1'b1; set_L = 1'b0; set_R = 1'b0; set_M = 1'b0; A_in = a;
    step();
    idle_strobes();
    A_in = 8'hff;
  endtask

  task automatic do_iter();
    set_M = 1'b1; set_L = 1'b0; set_R = 1'b0;
    step();
    set_L = 1'b1; set_R = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_strobes();
    A_in = 8'd0;
    #12;
    checks++;
    if (F !== 1'b0 || NF !== 1'b0) begin
      errors++; $display("FAIL reset_flags: F=%b NF=%b required 0 0", F, NF);
    end
    checks++;
    if (found_addr !== 5'd0 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_addr: found_addr=%0d mem_addr=%0d required 0 0", found_addr, mem_addr);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_search(input logic [7:0] a, input int n, input int seq[8],
                            input logic exp_f, input string name);
    do_init(a);
    #3;
    checks++;
    if (F !== 1'b0 || NF !== 1'b0 || found_addr !== 5'd0 || mem_addr !== 5'd15) begin
      errors++;
      $display("FAIL %s_init: F=%b NF=%b found_addr=%0d mem_addr=%0d required 0 0 0 15",
               name, F, NF, found_addr, mem_addr);
    end
    for (int i = 0; i < n; i++) begin
      do_iter();
      #3;
      checks++;
      if (found_addr !== 5'(seq[i]) || F !== (exp_f && i == n - 1) ||
          NF !== (!exp_f && i == n - 1)) begin
        errors++;
        $display("FAIL %s_cmp%0d: M=%0d F=%b NF=%b required M=%0d F=%b NF=%b", name, i,
                 found_addr, F, NF, seq[i], exp_f && i == n - 1, !exp_f && i == n - 1);
      end
      step();
    end
    idle_strobes();
    #3;
    checks++;
    if (F !== exp_f || NF !== !exp_f || found_addr !== 5'(seq[n-1])) begin
      errors++;
      $display("FAIL %s_sticky: F=%b NF=%b found_addr=%0d required %b %b %0d", name, F, NF,
               found_addr, exp_f, !exp_f, seq[n-1]);
    end
`ifdef BSEARCH_STATS_EN
    checks++;
    if (probes !== 6'(n)) begin
      errors++; $display("FAIL %s_probes: probes=%0d required %0d", name, probes, n);
    end
`endif
    step();
  endtask

  task automatic test_found();
    run_search(8'd20, 5, '{15, 7, 11, 9, 10, 0, 0, 0}, 1'b1, "a20");
    run_search(8'd0, 5, '{15, 7, 3, 1, 0, 0, 0, 0}, 1'b1, "a0");
    run_search(8'd62, 6, '{15, 23, 27, 29, 30, 31, 0, 0}, 1'b1, "a62");
  endtask

  task automatic test_not_found();
    run_search(8'd63, 6, '{15, 23, 27, 29, 30, 31, 0, 0}, 1'b0, "a63");
    run_search(8'd21, 5, '{15, 7, 11, 9, 10, 0, 0, 0}, 1'b0, "a21");
  endtask

  task automatic test_back_to_back();
    run_search(8'd21, 5, '{15, 7, 11, 9, 10, 0, 0, 0}, 1'b0, "rerun_nf");
    run_search(8'd44, 5, '{15, 23, 19, 21, 22, 0, 0, 0}, 1'b1, "rerun_f");
  endtask

  task automatic test_hold();
    do_init(8'd20);
    set_L = 1'b1;
    step();
    set_L = 1'b0; set_R = 1'b1;
    step();
    set_R = 1'b1; set_M = 1'b1; set_L = 1'b0;
    step();
    idle_strobes();
    #3;
    checks++;
    if (mem_addr !== 5'd15 || found_addr !== 5'd0 || F !== 1'b0 || NF !== 1'b0) begin
      errors++;
      $display("FAIL hold: mem_addr=%0d found_addr=%0d F=%b NF=%b required 15 0 0 0",
               mem_addr, found_addr, F, NF);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_init(8'd20);
    do_iter(); step();
    do_iter(); step();
    idle_strobes();
    #3;
    checks++;
    if (found_addr !== 5'd7 || mem_addr !== 5'd11) begin
      errors++;
      $display("FAIL mid_state: found_addr=%0d mem_addr=%0d required 7 11", found_addr, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (found_addr !== 5'd0 || mem_addr !== 5'd0 || F !== 1'b0 || NF !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: found_addr=%0d mem_addr=%0d F=%b NF=%b required 0 0 0 0",
               found_addr, mem_addr, F, NF);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset_found();
    run_search(8'd62, 6, '{15, 23, 27, 29, 30, 31, 0, 0}, 1'b1, "pre_reset");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (F !== 1'b0 || NF !== 1'b0 || found_addr !== 5'd0) begin
      errors++;
      $display("FAIL found_reset: F=%b NF=%b found_addr=%0d required 0 0 0", F, NF, found_addr);
    end
`ifdef BSEARCH_STATS_EN
    checks++;
    if (probes !== 6'd0) begin
      errors++; $display("FAIL found_reset_probes: probes=%0d required 0", probes);
    end
`endif
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_found();
    test_not_found();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_reset_found();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
